// File: rtl/sram_bist_if.sv
// SRAM user request interface between the BIST initiator and the SRAM core.
//
// Ports and parameters:
//   ADDR_WIDTH  word address width
//   DATA_WIDTH  word width
//   mem_addr    request address       (master -> slave)
//   mem_wdata   request write data    (master -> slave)
//   mem_enable  request valid         (master -> slave)
//   mem_rnw     1 = read, 0 = write   (master -> slave)
//   mem_rdata   read data             (slave -> master)
//   mem_ready   operation complete    (slave -> master)
interface sram_bist_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_enable;
    logic                  mem_rnw;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ready;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_enable,
        output mem_rnw,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_enable,
        input  mem_rnw,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/sram_bist.sv
// March C- built-in self-test initiator for the SRAM macro.
//
// Runs M0..M5 (w0 / r0,w1 / r1,w0 / desc r0,w1 / desc r1,w0 / r0) over
// every word, one request at a time with a one-cycle gap between requests.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   start       one-cycle pulse that begins a test (ignored while busy)
//   busy        test in progress
//   done        one-cycle pulse at the end of a test
//   pass        1 when the last test saw no mismatch and no timeout
//   timeout     sticky: a request waited TIMEOUT cycles without mem_ready
//   err_count   saturating mismatch count
//   fail_addr   address of the first mismatch
//   fail_exp    expected data of the first mismatch
//   fail_got    read data of the first mismatch
//   mem         SRAM request interface (master side)
module sram_bist #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [7:0]            err_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_exp,
    output logic [DATA_WIDTH-1:0] fail_got,
    sram_bist_if.master           mem
);

    localparam int                    CNT_WIDTH = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
    localparam logic [DATA_WIDTH-1:0] ALL_ONES  = '1;
    localparam logic [CNT_WIDTH-1:0]  CNT_LAST  = CNT_WIDTH'(TIMEOUT - 1);
    localparam logic [7:0]            ERR_MAX   = 8'hFF;
    localparam logic [2:0]            ELEM_LAST = 3'd5;

    typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_t;

    state_t                state, state_next;
    logic [2:0]            elem, elem_next;
    logic                  op, op_next;
    logic [ADDR_WIDTH-1:0] addr, addr_next;
    logic [DATA_WIDTH-1:0] wdata, wdata_next;
    logic                  enable, enable_next;
    logic                  rnw, rnw_next;
    logic [CNT_WIDTH-1:0]  cnt, cnt_next;
    logic                  busy_next, done_next, pass_next, timeout_next;
    logic [7:0]            err_next;
    logic [ADDR_WIDTH-1:0] fail_addr_next;
    logic [DATA_WIDTH-1:0] fail_exp_next, fail_got_next;

    logic [DATA_WIDTH-1:0] read_bg;
    logic                  mismatch, descending, last_op, last_addr;

    // op selects the first (0) or second (1) operation of an element.
    // M0 has only a write, M5 only a read; M1..M4 are read then write.
    function automatic logic op_is_read(input logic [2:0] e, input logic o);
        return (e != 3'd0) && !o;
    endfunction

    // Odd elements write ones, even elements write zeros; reads drive zero.
    function automatic logic [DATA_WIDTH-1:0] op_wdata(input logic [2:0] e, input logic o);
        return (op_is_read(e, o) || !e[0]) ? '0 : ALL_ONES;
    endfunction

    assign mem.mem_addr   = addr;
    assign mem.mem_wdata  = wdata;
    assign mem.mem_enable = enable;
    assign mem.mem_rnw    = rnw;

    always_comb begin
        state_next     = state;
        elem_next      = elem;
        op_next        = op;
        addr_next      = addr;
        wdata_next     = wdata;
        enable_next    = enable;
        rnw_next       = rnw;
        cnt_next       = cnt;
        busy_next      = busy;
        done_next      = 1'b0;
        pass_next      = pass;
        timeout_next   = timeout;
        err_next       = err_count;
        fail_addr_next = fail_addr;
        fail_exp_next  = fail_exp;
        fail_got_next  = fail_got;

        // Reads in odd elements expect zeros, in even elements ones.
        read_bg    = elem[0] ? '0 : ALL_ONES;
        mismatch   = (state == REQ) && mem.mem_ready && rnw && (mem.mem_rdata != read_bg);
        descending = (elem == 3'd3) || (elem == 3'd4);
        last_op    = (elem == 3'd0) || (elem == ELEM_LAST) || op;
        last_addr  = descending ? (addr == '0) : (addr == ADDR_LAST);

        case (state)
            IDLE, DONE: begin
                // A start during the done pulse is honoured directly.
                if (start) begin
                    state_next     = REQ;
                    busy_next      = 1'b1;
                    pass_next      = 1'b0;
                    timeout_next   = 1'b0;
                    err_next       = '0;
                    fail_addr_next = '0;
                    fail_exp_next  = '0;
                    fail_got_next  = '0;
                    elem_next      = '0;
                    op_next        = 1'b0;
                    addr_next      = '0;
                    rnw_next       = 1'b0;
                    wdata_next     = '0;
                    enable_next    = 1'b1;
                    cnt_next       = '0;
                end else begin
                    state_next = IDLE;
                end
            end
            REQ: begin
                if (mem.mem_ready) begin
                    state_next  = GAP;
                    enable_next = 1'b0;
                    if (mismatch) begin
                        if (err_count == 8'd0) begin
                            fail_addr_next = addr;
                            fail_exp_next  = read_bg;
                            fail_got_next  = mem.mem_rdata;
                        end
                        if (err_count != ERR_MAX) begin
                            err_next = err_count + 8'd1;
                        end
                    end
                end else if (cnt == CNT_LAST) begin
                    state_next   = DONE;
                    enable_next  = 1'b0;
                    busy_next    = 1'b0;
                    done_next    = 1'b1;
                    pass_next    = 1'b0;
                    timeout_next = 1'b1;
                    rnw_next     = 1'b1;
                    addr_next    = '0;
                    wdata_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_WIDTH'(1);
                end
            end
            GAP: begin
                state_next  = REQ;
                enable_next = 1'b1;
                cnt_next    = '0;
                if (!last_op) begin
                    op_next = 1'b1;
                end else if (!last_addr) begin
                    op_next   = 1'b0;
                    addr_next = descending ? addr - ADDR_WIDTH'(1) : addr + ADDR_WIDTH'(1);
                end else if (elem == ELEM_LAST) begin
                    state_next  = DONE;
                    enable_next = 1'b0;
                    busy_next   = 1'b0;
                    done_next   = 1'b1;
                    pass_next   = (err_count == 8'd0);
                    op_next     = 1'b0;
                    addr_next   = '0;
                end else begin
                    // M3 and M4 walk downwards, so they start at the top word.
                    elem_next = elem + 3'd1;
                    op_next   = 1'b0;
                    addr_next = ((elem == 3'd2) || (elem == 3'd3)) ? ADDR_LAST : '0;
                end
                // On the DONE path this resolves to the idle read/zero values.
                rnw_next   = op_is_read(elem_next, op_next);
                wdata_next = op_wdata(elem_next, op_next);
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            elem      <= '0;
            op        <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            enable    <= 1'b0;
            rnw       <= 1'b1;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_got  <= '0;
        end else begin
            state     <= state_next;
            elem      <= elem_next;
            op        <= op_next;
            addr      <= addr_next;
            wdata     <= wdata_next;
            enable    <= enable_next;
            rnw       <= rnw_next;
            cnt       <= cnt_next;
            busy      <= busy_next;
            done      <= done_next;
            pass      <= pass_next;
            timeout   <= timeout_next;
            err_count <= err_next;
            fail_addr <= fail_addr_next;
            fail_exp  <= fail_exp_next;
            fail_got  <= fail_got_next;
        end
    end

endmodule

// File: tb/tb_sram_bist.sv
// Self-checking bench for sram_bist: a 16-word instance against a behavioural
// SRAM with selectable faults, plus a 1024-word instance against a memory whose
// every word reads 4'hA.
module tb_sram_bist;

    localparam int AW     = 4;
    localparam int DW     = 4;
    localparam int AW_BIG = 10;

    localparam int MODE_GOOD   = 0;
    localparam int MODE_SA1_B2 = 1;
    localparam int MODE_NORDY  = 2;
    localparam int MODE_SA0_B0 = 3;
    localparam int MODE_TWO    = 4;
    localparam int MODE_FAST   = 5;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          start     = 1'b0;
    logic          start_big = 1'b0;

    logic          busy, done, pass, timeout;
    logic [7:0]    err_count;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_exp, fail_got;

    logic              busy_big, done_big, pass_big, timeout_big;
    logic [7:0]        err_big;
    logic [AW_BIG-1:0] fail_addr_big;
    logic [DW-1:0]     fail_exp_big, fail_got_big;

    sram_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW))     bus ();
    sram_bist_if #(.ADDR_WIDTH(AW_BIG), .DATA_WIDTH(DW)) bus_big ();

    always #5 clk = ~clk;

    sram_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .start(start),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_count(err_count), .fail_addr(fail_addr),
        .fail_exp(fail_exp), .fail_got(fail_got),
        .mem(bus)
    );

    sram_bist #(.ADDR_WIDTH(AW_BIG), .DATA_WIDTH(DW), .TIMEOUT(15)) dut_big (
        .clk(clk), .rst(rst), .start(start_big),
        .busy(busy_big), .done(done_big), .pass(pass_big), .timeout(timeout_big),
        .err_count(err_big), .fail_addr(fail_addr_big),
        .fail_exp(fail_exp_big), .fail_got(fail_got_big),
        .mem(bus_big)
    );

    // Behavioural SRAM: ready one cycle after the request is seen, so a
    // request lasts two cycles; writes commit in the ready cycle.
    int            mode = MODE_GOOD;
    logic [DW-1:0] mem_array [0:(1<<AW)-1];
    logic          rdy_q = 1'b0;
    logic [DW-1:0] raw_rdata;

    always @(posedge clk) begin
        rdy_q <= bus.mem_enable && !rdy_q;
        if (bus.mem_enable && bus.mem_ready && !bus.mem_rnw)
            mem_array[bus.mem_addr] <= bus.mem_wdata;
    end

    // Fault injection on the read path and ready behaviour per mode.
    always_comb begin
        raw_rdata     = mem_array[bus.mem_addr];
        bus.mem_rdata = raw_rdata;
        case (mode)
            MODE_SA1_B2: if (bus.mem_addr == 4'd5) bus.mem_rdata = raw_rdata | 4'h4;
            MODE_SA0_B0: if (bus.mem_addr == 4'd9) bus.mem_rdata = raw_rdata & 4'hE;
            MODE_TWO: begin
                if (bus.mem_addr == 4'd5)  bus.mem_rdata = raw_rdata | 4'h2;
                if (bus.mem_addr == 4'd12) bus.mem_rdata = raw_rdata | 4'h8;
            end
            default: ;
        endcase
        if (mode == MODE_NORDY)     bus.mem_ready = 1'b0;
        else if (mode == MODE_FAST) bus.mem_ready = 1'b1;
        else                        bus.mem_ready = rdy_q;
    end

    // Large memory: every word reads 4'hA regardless of writes.
    logic rdy_big_q = 1'b0;
    always @(posedge clk) rdy_big_q <= bus_big.mem_enable && !rdy_big_q;
    assign bus_big.mem_ready = rdy_big_q;
    assign bus_big.mem_rdata = 4'hA;

    int checks = 0;
    int errors = 0;

    logic trace_rnw [$];
    int   trace_addr [$];
    int   trace_wdata [$];
    int   busy_t1;

    // March C- reference: ops per element, first op is a read, descending, write data.
    int elem_ops   [6] = '{1, 2, 2, 2, 2, 1};
    int elem_rfirst[6] = '{0, 1, 1, 1, 1, 1};
    int elem_desc  [6] = '{0, 0, 0, 1, 1, 0};
    int elem_wd    [6] = '{0, 15, 0, 15, 0, 0};

    typedef struct {
        int    mode;
        string name;
        int    exp_pass;
        int    exp_timeout;
        int    exp_err;
        int    exp_fail_addr;
        int    exp_fail_exp;
        int    exp_fail_got;
        int    exp_cycles;
        int    exp_en_cycles;
        int    exp_ops;
    } vec_t;

    vec_t vecs [6];

    task automatic check_output(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("[TB] FAIL %s: actual %0d required %0d", name, actual, required);
        end
    endtask

    task automatic apply_stimulus(input int m);
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        mode  = m;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Pulses start, then follows the run until done or the budget expires.
    // cycles counts the start cycle as 1 and includes the done cycle.
    task automatic run_test(input int budget, input int extra_start_at,
                            output int cycles, output int en_cycles,
                            output int gap_bad, output bit done_seen);
        bit prev_en;
        int gap_len;
        trace_rnw.delete();
        trace_addr.delete();
        trace_wdata.delete();
        cycles    = 1;
        en_cycles = 0;
        gap_bad   = 0;
        done_seen = 1'b0;
        prev_en   = 1'b0;
        gap_len   = 0;
        busy_t1   = 0;
        @(negedge clk);
        start = 1'b1;
        while (!done_seen && cycles < budget) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            cycles++;
            if (cycles == extra_start_at) start = 1'b1;
            if (cycles == 2) busy_t1 = int'(busy);
            if (bus.mem_enable) begin
                en_cycles++;
                if (!prev_en) begin
                    if (trace_addr.size() > 0 && gap_len != 1) gap_bad++;
                    trace_rnw.push_back(bus.mem_rnw);
                    trace_addr.push_back(int'(bus.mem_addr));
                    trace_wdata.push_back(int'(bus.mem_wdata));
                end
                gap_len = 0;
            end else begin
                gap_len++;
            end
            prev_en   = bus.mem_enable;
            done_seen = done;
        end
    endtask

    function automatic int trace_addr_at(input int idx);
        return (idx < trace_addr.size()) ? trace_addr[idx] : -1;
    endfunction

    function automatic int trace_rnw_at(input int idx);
        return (idx < trace_rnw.size()) ? int'(trace_rnw[idx]) : -1;
    endfunction

    initial begin
        int   cyc, enc, gb, bad, idx, a, n, ops_seen, en_count;
        bit   ds, is_read, prev;
        vec_t v;

        vecs[0] = '{MODE_GOOD,   "good",    1, 0, 0, 0, 0,  0,  482, 320, 160};
        vecs[1] = '{MODE_SA1_B2, "sa1_b2",  0, 0, 3, 5, 0,  4,  482, 320, 160};
        vecs[2] = '{MODE_SA0_B0, "sa0_b0",  0, 0, 2, 9, 15, 14, 482, 320, 160};
        vecs[3] = '{MODE_TWO,    "two",     0, 0, 6, 5, 0,  2,  482, 320, 160};
        vecs[4] = '{MODE_NORDY,  "noready", 0, 1, 0, 0, 0,  0,  17,  15,  1};
        vecs[5] = '{MODE_FAST,   "fast",    1, 0, 0, 0, 0,  0,  322, 160, 160};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_output("rst.busy",      int'(busy), 0);
        check_output("rst.done",      int'(done), 0);
        check_output("rst.pass",      int'(pass), 0);
        check_output("rst.timeout",   int'(timeout), 0);
        check_output("rst.err",       int'(err_count), 0);
        check_output("rst.fail_addr", int'(fail_addr), 0);
        check_output("rst.fail_exp",  int'(fail_exp), 0);
        check_output("rst.fail_got",  int'(fail_got), 0);
        check_output("rst.enable",    int'(bus.mem_enable), 0);
        check_output("rst.rnw",       int'(bus.mem_rnw), 1);
        check_output("rst.addr",      int'(bus.mem_addr), 0);
        check_output("rst.wdata",     int'(bus.mem_wdata), 0);

        // Table of full runs
        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            apply_stimulus(v.mode);
            run_test(2000, -1, cyc, enc, gb, ds);
            check_output({v.name, ".done_seen"}, int'(ds), 1);
            check_output({v.name, ".cycles"},    cyc, v.exp_cycles);
            check_output({v.name, ".en_cycles"}, enc, v.exp_en_cycles);
            check_output({v.name, ".ops"},       trace_addr.size(), v.exp_ops);
            check_output({v.name, ".gaps"},      gb, 0);
            check_output({v.name, ".busy_t1"},   busy_t1, 1);
            check_output({v.name, ".busy_done"}, int'(busy), 0);
            check_output({v.name, ".en_done"},   int'(bus.mem_enable), 0);
            check_output({v.name, ".pass"},      int'(pass), v.exp_pass);
            check_output({v.name, ".timeout"},   int'(timeout), v.exp_timeout);
            check_output({v.name, ".err"},       int'(err_count), v.exp_err);
            check_output({v.name, ".fail_addr"}, int'(fail_addr), v.exp_fail_addr);
            check_output({v.name, ".fail_exp"},  int'(fail_exp), v.exp_fail_exp);
            check_output({v.name, ".fail_got"},  int'(fail_got), v.exp_fail_got);
            @(posedge clk);
            #1;
            check_output({v.name, ".done_pulse"}, int'(done), 0);
            check_output({v.name, ".pass_held"},  int'(pass), v.exp_pass);
            check_output({v.name, ".to_held"},    int'(timeout), v.exp_timeout);
        end

        // Address order trace, with a start pulse while busy
        apply_stimulus(MODE_SA1_B2);
        run_test(2000, 100, cyc, enc, gb, ds);
        check_output("trace.cycles", cyc, 482);
        check_output("trace.ops", trace_addr.size(), 160);
        check_output("trace.gaps", gb, 0);
        bad = 0;
        idx = 0;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < 16; k++) begin
                a = (elem_desc[e] != 0) ? 15 - k : k;
                for (int o = 0; o < elem_ops[e]; o++) begin
                    is_read = (o == 0) && (elem_rfirst[e] != 0);
                    if (idx >= trace_addr.size()) bad++;
                    else if (trace_rnw[idx] != is_read || trace_addr[idx] != a) bad++;
                    else if (!is_read && trace_wdata[idx] != elem_wd[e]) bad++;
                    idx++;
                end
            end
        end
        check_output("trace.order", bad, 0);
        check_output("trace.op0_rnw", trace_rnw_at(0), 0);
        check_output("trace.m3_addr", trace_addr_at(80), 15);
        check_output("trace.m3_rnw",  trace_rnw_at(80), 1);
        check_output("trace.m5_addr", trace_addr_at(159), 15);
        check_output("trace.m5_rnw",  trace_rnw_at(159), 1);
        check_output("trace.err", int'(err_count), 3);

        // Start in the done cycle restarts immediately and clears results
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_output("restart.busy",   int'(busy), 1);
        check_output("restart.enable", int'(bus.mem_enable), 1);
        check_output("restart.rnw",    int'(bus.mem_rnw), 0);
        check_output("restart.addr",   int'(bus.mem_addr), 0);
        check_output("restart.err",    int'(err_count), 0);

        // Run into M2 (op 53), then reset mid-test
        ops_seen = 1;
        prev     = 1'b1;
        n        = 0;
        while (ops_seen < 54 && n < 600) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.mem_enable && !prev) ops_seen++;
            prev = bus.mem_enable;
        end
        check_output("midrst.reach_m2", ops_seen, 54);
        check_output("midrst.err_m1", int'(err_count), 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_output("midrst.busy",      int'(busy), 0);
        check_output("midrst.enable",    int'(bus.mem_enable), 0);
        check_output("midrst.rnw",       int'(bus.mem_rnw), 1);
        check_output("midrst.addr",      int'(bus.mem_addr), 0);
        check_output("midrst.err",       int'(err_count), 0);
        check_output("midrst.fail_addr", int'(fail_addr), 0);
        check_output("midrst.fail_got",  int'(fail_got), 0);
        @(negedge clk);
        rst  = 1'b0;
        mode = MODE_GOOD;
        en_count = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (bus.mem_enable) en_count++;
        end
        check_output("midrst.no_req", en_count, 0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_output("rerun.enable", int'(bus.mem_enable), 1);
        check_output("rerun.rnw",    int'(bus.mem_rnw), 0);
        check_output("rerun.addr",   int'(bus.mem_addr), 0);
        check_output("rerun.wdata",  int'(bus.mem_wdata), 0);
        check_output("rerun.err",    int'(err_count), 0);
        n = 0;
        while (!done && n < 600) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output("rerun.done", int'(done), 1);
        check_output("rerun.pass", int'(pass), 1);
        check_output("rerun.err_end", int'(err_count), 0);

        // 1024 words all reading 4'hA: error count saturates
        @(negedge clk);
        start_big = 1'b1;
        @(posedge clk);
        #1;
        start_big = 1'b0;
        n = 0;
        while (!done_big && n < 40000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output("big.done",      int'(done_big), 1);
        check_output("big.cycles",    n, 30720);
        check_output("big.err",       int'(err_big), 255);
        check_output("big.fail_addr", int'(fail_addr_big), 0);
        check_output("big.fail_exp",  int'(fail_exp_big), 0);
        check_output("big.fail_got",  int'(fail_got_big), 10);
        check_output("big.pass",      int'(pass_big), 0);
        check_output("big.timeout",   int'(timeout_big), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_bist.md
# sram_bist

Built-in self-test initiator for the SRAM macro. It drives the SRAM user request interface (address, write data, enable, read/write select) from the master side and consumes its data and ready responses. On a start pulse it runs a March C- sequence over every word and reports pass/fail, the first failing address and data, and a saturating error count. It sits between the chip-level pin logic and the SRAM core, and the pin logic muxes the SRAM interface between user and BIST.

## Interface
Parameters:
- ADDR_WIDTH, 10: word address width; the test covers 2^ADDR_WIDTH words.
- DATA_WIDTH, 4: word width.
- TIMEOUT, 15: maximum cycles to wait for mem_ready per operation.

Ports. One clock; reset is synchronous and active-high.
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse that begins a test; ignored while busy.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the test ends (normally or by timeout).
- pass  out  1  valid from done until the next start; 1 means zero mismatches and no timeout.
- timeout  out  1  sticky until start: an operation exceeded TIMEOUT.
- err_count  out  8  mismatch count, saturating at 255.
- fail_addr  out  ADDR_WIDTH  address of the first mismatch.
- fail_exp  out  DATA_WIDTH  expected data of the first mismatch.
- fail_got  out  DATA_WIDTH  read data of the first mismatch.
- mem_addr  out  ADDR_WIDTH  SRAM address.
- mem_wdata  out  DATA_WIDTH  SRAM write data.
- mem_enable  out  1  SRAM request.
- mem_rnw  out  1  1 = read, 0 = write.
- mem_rdata  in  DATA_WIDTH  SRAM read data.
- mem_ready  in  1  SRAM operation complete.

## Operation
- Backgrounds: D0 = all zeros, D1 = all ones.
- March elements, in order:
  - M0 ascending: w D0.
  - M1 ascending: r D0, w D1.
  - M2 ascending: r D1, w D0.
  - M3 descending: r D0, w D1.
  - M4 descending: r D1, w D0.
  - M5 ascending: r D0.
- Within an element, all of an address's ops complete before the address advances. Ascending runs 0 to 2^ADDR_WIDTH-1; descending runs the reverse.
- FSM states and transitions:
  - IDLE: on start, clear err_count, fail_*, timeout and pass, then go to REQ.
  - REQ: drive addr, wdata and rnw for the current op with mem_enable=1. Stay until mem_ready=1, then go to GAP.
  - GAP: mem_enable=0 for exactly one cycle. Advance op, address and element. Go to REQ, or to DONE after the last M5 read.
  - DONE: pulse done, set pass, return to IDLE.
- Read check: in the REQ cycle where mem_ready=1 and mem_rnw=1, compare mem_rdata against the expected background.
  - On mismatch, err_count increments, saturating at 255.
  - fail_addr, fail_exp and fail_got capture only the first mismatch.
- The test continues after mismatches and does not stop early.
- Timeout: a per-op counter resets on entry to REQ. If TIMEOUT cycles pass without mem_ready, set timeout, drop mem_enable and go to DONE with pass=0.
- Outputs are held stable for the whole REQ interval. Request outputs are registered.

## Timing
- Reset values:
  - busy=0, done=0, pass=0, timeout=0, err_count=0.
  - fail_addr=0, fail_exp=0, fail_got=0.
  - mem_enable=0, mem_rnw=1, mem_addr=0, mem_wdata=0.
  - FSM in IDLE.
- Reset mid-test aborts immediately: the next cycle shows reset values and no further requests.
- Start: sampled in IDLE at cycle T. busy=1 and the first REQ (M0, addr 0, write D0) both begin at T+1.
- Per op: REQ lasts until the mem_ready cycle inclusive, followed by a 1-cycle GAP. Against an SRAM with ready 2 cycles after enable, each op costs 3 cycles.
- Total ops = 10 × 2^ADDR_WIDTH, which is 10240 at default.
- done pulses one cycle after the final GAP. busy falls in the same cycle done pulses.
- start asserted while busy has no effect. start in the same cycle as done's IDLE return is honoured.
- mem_ready is ignored outside REQ.
- A mem_ready in the first REQ cycle completes the op, so the minimum REQ length is 1.

## Test plan
- Good memory (behavioural model, ready 2 cycles after enable), ADDR_WIDTH=4: start -> 160 ops, first op write addr 0 data 0, done after 480+2 cycles, pass=1, err_count=0.
- Stuck-at-1 on bit 2 at addr 5, ADDR_WIDTH=4: start -> pass=0, fail_addr=5, fail_exp=4'h0, fail_got=4'h4, err_count=3 (M1, M3 and M5 read 0).
- Address order trace, ADDR_WIDTH=4: start -> M3 begins with read addr 15 exp 0; M5 ends with read addr 15; one GAP (mem_enable=0) between every op.
- SRAM never asserts ready: start -> mem_enable high for 15 cycles, then timeout=1, done pulse, pass=0, mem_enable=0.
- Reset asserted mid-M2: all outputs return to reset values the next cycle; a subsequent start reruns from M0 addr 0 with err_count=0.
- Every word stuck at 4'hA, ADDR_WIDTH=10: err_count saturates at 255, fail_addr=0, fail_exp=0, fail_got=4'hA.
